// File: rtl/nlf_pkg.sv
// Shared constants for the nonlinear-function datapath (constant_mul, pow2_unit).
package nlf_pkg;
  localparam int FPW_DEF        = 16;
  localparam int BF_DEF         = 8;
  localparam int POW2_I_MAX     = FPW_DEF - 1 - BF_DEF;
  localparam int POW2_SHIFT_MAX = BF_DEF + 1;
  localparam logic [FPW_DEF-1:0] SAT_POS = {1'b0, {(FPW_DEF-1){1'b1}}};

  // Shift-amount width: covers both the left range (< I_MAX) and the right clamp (Bf+1).
  function automatic int pow2_sh_w(input int w);
    return $clog2(w) + 1;
  endfunction
endpackage

// File: rtl/pow2_unit_if.sv
// Valid/ready sample stream into and out of pow2_unit.
interface pow2_unit_if #(
  parameter int FIX_POINT_WIDTH = 16,
  parameter int TAG_W           = 3
);
  logic                              in_valid;
  logic                              in_ready;
  logic signed [FIX_POINT_WIDTH-1:0] in_data;
  logic [TAG_W-1:0]                  in_tag;
  logic                              out_valid;
  logic                              out_ready;
  logic signed [FIX_POINT_WIDTH-1:0] out_data;
  logic [TAG_W-1:0]                  out_tag;
  logic                              out_sat;

  modport slave  (input  in_valid, in_data, in_tag, out_ready,
                  output in_ready, out_valid, out_data, out_tag, out_sat);
  modport master (output in_valid, in_data, in_tag, out_ready,
                  input  in_ready, out_valid, out_data, out_tag, out_sat);
endinterface

// File: rtl/pow2_unit_shifter.sv
// Barrel shift of the Mitchell mantissa, with overflow clamped to the max positive value.
module pow2_shifter
  import nlf_pkg::*;
#(
  parameter int W    = FPW_DEF,
  parameter int Bf   = BF_DEF,
  parameter int SH_W = pow2_sh_w(FPW_DEF)
) (
  input  logic [Bf:0]     m,
  input  logic [SH_W-1:0] sh,
  input  logic            left,
  input  logic            ovf,
  output logic [W-1:0]    res,
  output logic            sat
);
  localparam logic [W-1:0] SAT = {1'b0, {(W-1){1'b1}}};

  logic [W-1:0] ext;
  assign ext = W'(m);

  always_comb begin
    res = '0;
    sat = ovf;
    if (ovf)       res = SAT;
    else if (left) res = ext << sh;
    else           res = ext >> sh;
  end
endmodule

// File: rtl/pow2_unit.sv
// 2^x for signed Q.Bf input: 3-stage pipeline, linear mantissa, single global stall.
module pow2_unit
  import nlf_pkg::*;
#(
  parameter int FIX_POINT_WIDTH = FPW_DEF,
  parameter int Bf              = BF_DEF,
  parameter int TAG_W           = 3
) (
  input  logic       clk,
  input  logic       rst_n,
  pow2_unit_if.slave bus
);
  localparam int I_W    = FIX_POINT_WIDTH - Bf;
  localparam int I_MAX  = FIX_POINT_WIDTH - 1 - Bf;
  localparam int SH_MAX = Bf + 1;
  localparam int SH_W   = pow2_sh_w(FIX_POINT_WIDTH);
  localparam logic signed [I_W-1:0] I_MAX_S  = I_W'(I_MAX);
  localparam logic signed [I_W:0]   SH_MAX_S = (I_W+1)'(SH_MAX);
  localparam logic [SH_W-1:0]       SH_CLAMP = SH_W'(SH_MAX);

  logic [3:1] vld_pipe;
  logic       en;

  logic signed [I_W-1:0] s1_i;
  logic [Bf-1:0]         s1_f;
  logic [TAG_W-1:0]      s1_tag;

  logic [Bf:0]           s2_m;
  logic [SH_W-1:0]       s2_sh;
  logic                  s2_left, s2_ovf;
  logic [TAG_W-1:0]      s2_tag;

  logic [FIX_POINT_WIDTH-1:0] s3_data;
  logic                       s3_sat;
  logic [TAG_W-1:0]           s3_tag;

  logic signed [I_W:0]   i_ext, neg_i;
  logic [SH_W-1:0]       nx_sh;
  logic                  nx_left, nx_ovf;
  logic [FIX_POINT_WIDTH-1:0] sh_res;
  logic                  sh_sat;

  // Stall only when the output register holds an untaken result.
  assign en           = bus.out_ready || !vld_pipe[3];
  assign bus.in_ready = en;

  // Widen before negating so the most negative integer part still negates cleanly.
  assign i_ext = {s1_i[I_W-1], s1_i};
  assign neg_i = -i_ext;

  always_comb begin
    nx_left = ~s1_i[I_W-1];
    nx_ovf  = (s1_i >= I_MAX_S);
    nx_sh   = '0;
    if (nx_ovf)              nx_sh = '0;
    else if (nx_left)        nx_sh = SH_W'(s1_i);
    else if (neg_i >= SH_MAX_S) nx_sh = SH_CLAMP;
    else                     nx_sh = SH_W'(neg_i);
  end

  pow2_shifter #(.W(FIX_POINT_WIDTH), .Bf(Bf), .SH_W(SH_W)) u_shifter (
    .m(s2_m), .sh(s2_sh), .left(s2_left), .ovf(s2_ovf), .res(sh_res), .sat(sh_sat)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_pipe <= '0;
      s1_i     <= '0;
      s1_f     <= '0;
      s1_tag   <= '0;
      s2_m     <= '0;
      s2_sh    <= '0;
      s2_left  <= 1'b0;
      s2_ovf   <= 1'b0;
      s2_tag   <= '0;
      s3_data  <= '0;
      s3_sat   <= 1'b0;
      s3_tag   <= '0;
    end else if (en) begin
      vld_pipe <= {vld_pipe[2:1], bus.in_valid};
      s1_i     <= bus.in_data[FIX_POINT_WIDTH-1:Bf];
      s1_f     <= bus.in_data[Bf-1:0];
      s1_tag   <= bus.in_tag;
      s2_m     <= {1'b1, s1_f};
      s2_sh    <= nx_sh;
      s2_left  <= nx_left;
      s2_ovf   <= nx_ovf;
      s2_tag   <= s1_tag;
      s3_data  <= sh_res;
      s3_sat   <= sh_sat;
      s3_tag   <= s2_tag;
    end
  end

  assign bus.out_valid = vld_pipe[3];
  assign bus.out_data  = s3_data;
  assign bus.out_sat   = s3_sat;
  assign bus.out_tag   = s3_tag;
endmodule

// File: tb/tb_pow2_unit.sv
// Directed and randomized checks of pow2_unit at default parameters.
module tb_pow2_unit;
  logic clk = 1'b0;
  logic rst_n;
  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  pow2_unit_if #(.FIX_POINT_WIDTH(16), .TAG_W(3)) bus ();
  pow2_unit #(.FIX_POINT_WIDTH(16), .Bf(8), .TAG_W(3)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  // Reference: floor split by exact division, mantissa scaled by multiply/divide.
  function automatic logic [15:0] ref_pow2(input logic [15:0] x, output logic sat);
    int xi, fr, ip, m;
    xi = int'($signed(x));
    fr = xi & 255;
    ip = (xi - fr) / 256;
    m  = 256 + fr;
    sat = 1'b0;
    if (ip >= 7) begin sat = 1'b1; return 16'h7FFF; end
    if (ip >= 0) return 16'(m * (1 << ip));
    if (ip <= -9) return 16'h0000;
    return 16'(m / (1 << (-ip)));
  endfunction

  task automatic test_reset;
    rst_n = 1'b0; bus.in_valid = 1'b0; bus.in_data = '0; bus.in_tag = '0; bus.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL rst_valid: got %b exp 0", bus.out_valid); end
    total++; if (bus.out_data !== 16'h0000) begin bad++; $display("FAIL rst_data: got %h exp 0000", bus.out_data); end
    total++; if (bus.out_tag !== 3'd0) begin bad++; $display("FAIL rst_tag: got %0d exp 0", bus.out_tag); end
    total++; if (bus.out_sat !== 1'b0) begin bad++; $display("FAIL rst_sat: got %b exp 0", bus.out_sat); end
    total++; if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL rst_in_ready: got %b exp 1", bus.in_ready); end
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_basic;
    logic [15:0] xv [3];
    logic [15:0] ev [3];
    xv = '{16'h0000, 16'h0180, 16'hFF00};
    ev = '{16'h0100, 16'h0300, 16'h0080};
    for (int k = 0; k < 3; k++) begin
      bus.in_valid = 1'b1; bus.in_data = xv[k]; bus.in_tag = 3'(k + 2);
      @(posedge clk); #1; bus.in_valid = 1'b0;
      total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL basic_early1[%0d]: got %b exp 0", k, bus.out_valid); end
      @(posedge clk); #1;
      total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL basic_early2[%0d]: got %b exp 0", k, bus.out_valid); end
      @(posedge clk); #1;
      total++; if (bus.out_valid !== 1'b1) begin bad++; $display("FAIL basic_valid[%0d]: got %b exp 1", k, bus.out_valid); end
      total++; if (bus.out_data !== ev[k]) begin bad++; $display("FAIL basic_data[%0d]: got %h exp %h", k, bus.out_data, ev[k]); end
      total++; if (bus.out_sat !== 1'b0) begin bad++; $display("FAIL basic_sat[%0d]: got %b exp 0", k, bus.out_sat); end
      total++; if (bus.out_tag !== 3'(k + 2)) begin bad++; $display("FAIL basic_tag[%0d]: got %0d exp %0d", k, bus.out_tag, k + 2); end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_bounds;
    logic [15:0] xv [6];
    logic [15:0] ev [6];
    logic        sv [6];
    xv = '{16'h06FF, 16'h0700, 16'h7FFF, 16'hF800, 16'hF700, 16'h8000};
    ev = '{16'h7FC0, 16'h7FFF, 16'h7FFF, 16'h0001, 16'h0000, 16'h0000};
    sv = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    for (int k = 0; k < 6; k++) begin
      bus.in_valid = 1'b1; bus.in_data = xv[k]; bus.in_tag = 3'(k);
      @(posedge clk); #1; bus.in_valid = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      total++; if (bus.out_valid !== 1'b1) begin bad++; $display("FAIL bound_valid[%h]: got %b exp 1", xv[k], bus.out_valid); end
      total++; if (bus.out_data !== ev[k]) begin bad++; $display("FAIL bound_data[%h]: got %h exp %h", xv[k], bus.out_data, ev[k]); end
      total++; if (bus.out_sat !== sv[k]) begin bad++; $display("FAIL bound_sat[%h]: got %b exp %b", xv[k], bus.out_sat, sv[k]); end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_stream;
    logic [15:0] xv [8];
    logic [15:0] ev [8];
    logic        sv [8];
    for (int j = 0; j < 8; j++) begin
      xv[j] = 16'hFD00 + 16'(j) * 16'h0130;
      ev[j] = ref_pow2(xv[j], sv[j]);
    end
    for (int c = 0; c < 12; c++) begin
      bus.in_valid = (c < 8); bus.in_data = (c < 8) ? xv[c] : 16'h0; bus.in_tag = 3'(c);
      if (c < 8) begin
        total++; if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL stream_in_ready[%0d]: got %b exp 1", c, bus.in_ready); end
      end
      if (c >= 3 && c <= 10) begin
        total++;
        if (bus.out_valid !== 1'b1 || bus.out_data !== ev[c-3] || bus.out_tag !== 3'(c - 3)) begin
          bad++;
          $display("FAIL stream_out[%0d]: got v=%b d=%h t=%0d exp v=1 d=%h t=%0d",
                   c - 3, bus.out_valid, bus.out_data, bus.out_tag, ev[c-3], c - 3);
        end
      end else begin
        total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL stream_idle[%0d]: got %b exp 0", c, bus.out_valid); end
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_backpressure;
    logic [15:0] xv [4];
    logic [15:0] ev [4];
    logic        sv [4];
    xv = '{16'h0080, 16'h0200, 16'hFE40, 16'h0333};
    for (int j = 0; j < 4; j++) ev[j] = ref_pow2(xv[j], sv[j]);
    for (int c = 0; c < 3; c++) begin
      bus.in_valid = 1'b1; bus.in_data = xv[c]; bus.in_tag = 3'(c + 1);
      @(posedge clk); #1;
    end
    bus.in_data = xv[3]; bus.in_tag = 3'd4; bus.out_ready = 1'b0;
    for (int c = 0; c < 5; c++) begin
      #1;
      total++; if (bus.in_ready !== 1'b0) begin bad++; $display("FAIL bp_in_ready[%0d]: got %b exp 0", c, bus.in_ready); end
      total++;
      if (bus.out_valid !== 1'b1 || bus.out_data !== ev[0] || bus.out_tag !== 3'd1) begin
        bad++;
        $display("FAIL bp_hold[%0d]: got v=%b d=%h t=%0d exp v=1 d=%h t=1", c, bus.out_valid, bus.out_data, bus.out_tag, ev[0]);
      end
      @(posedge clk); #1;
    end
    bus.out_ready = 1'b1;
    for (int j = 0; j < 4; j++) begin
      #1;
      total++;
      if (bus.out_valid !== 1'b1 || bus.out_data !== ev[j] || bus.out_tag !== 3'(j + 1)) begin
        bad++;
        $display("FAIL bp_drain[%0d]: got v=%b d=%h t=%0d exp v=1 d=%h t=%0d", j, bus.out_valid, bus.out_data, bus.out_tag, ev[j], j + 1);
      end
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
    end
    total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL bp_dup: got %b exp 0", bus.out_valid); end
  endtask

  task automatic test_random;
    localparam int N = 10000;
    logic [19:0] q [$];
    logic [19:0] exp_e, held;
    logic [15:0] ed;
    logic        es, stalled;
    int sent = 0, rcvd = 0, cyc = 0;
    stalled = 1'b0; held = '0;
    while ((sent < N || rcvd < sent) && cyc < 60000) begin
      bus.out_ready = ($urandom_range(3) != 0);
      bus.in_valid  = (sent < N) && ($urandom_range(3) != 0);
      bus.in_data   = ($urandom_range(1) == 0) ? 16'($urandom) : 16'($urandom_range(0, 32'h1200)) - 16'h0A00;
      bus.in_tag    = 3'($urandom_range(7));
      @(negedge clk);
      total++;
      if (bus.in_ready !== (bus.out_ready || !bus.out_valid)) begin
        bad++; $display("FAIL rnd_in_ready: got %b exp %b", bus.in_ready, bus.out_ready || !bus.out_valid);
      end
      if (stalled) begin
        total++;
        if (bus.out_valid !== 1'b1 || {bus.out_sat, bus.out_tag, bus.out_data} !== held) begin
          bad++; $display("FAIL rnd_hold: got %h exp %h", {bus.out_sat, bus.out_tag, bus.out_data}, held);
        end
      end
      if (bus.out_valid && bus.out_ready) begin
        total++;
        if (q.size() == 0) begin
          bad++; $display("FAIL rnd_extra: got %h exp none", {bus.out_sat, bus.out_tag, bus.out_data});
        end else begin
          exp_e = q.pop_front();
          if ({bus.out_sat, bus.out_tag, bus.out_data} !== exp_e) begin
            bad++; $display("FAIL rnd_data[%0d]: got %h exp %h", rcvd, {bus.out_sat, bus.out_tag, bus.out_data}, exp_e);
          end
        end
        rcvd++;
      end
      stalled = bus.out_valid && !bus.out_ready;
      held = {bus.out_sat, bus.out_tag, bus.out_data};
      if (bus.in_valid && bus.in_ready) begin
        ed = ref_pow2(bus.in_data, es);
        q.push_back({es, bus.in_tag, ed});
        sent++;
      end
      @(posedge clk); #1;
      cyc++;
    end
    total++;
    if (cyc >= 60000) begin bad++; $display("FAIL rnd_timeout: got rcvd=%0d exp %0d", rcvd, N); end
    bus.in_valid = 1'b0; bus.out_ready = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid;
    logic [15:0] xv [3];
    xv = '{16'h0100, 16'hFF80, 16'h0040};
    for (int c = 0; c < 3; c++) begin
      bus.in_valid = 1'b1; bus.in_data = xv[c]; bus.in_tag = 3'(c + 5);
      @(posedge clk); #1;
    end
    bus.in_valid = 1'b0; bus.out_ready = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    total++;
    if (bus.out_valid !== 1'b0 || bus.out_data !== 16'h0 || bus.out_tag !== 3'd0 || bus.out_sat !== 1'b0) begin
      bad++; $display("FAIL mid_rst_out: got v=%b d=%h t=%0d s=%b exp all 0", bus.out_valid, bus.out_data, bus.out_tag, bus.out_sat);
    end
    repeat (2) @(posedge clk);
    @(negedge clk); rst_n = 1'b1; bus.out_ready = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(posedge clk); #1;
      total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL mid_stale[%0d]: got %b exp 0", c, bus.out_valid); end
    end
    bus.in_valid = 1'b1; bus.in_data = 16'h0280; bus.in_tag = 3'd6;
    @(posedge clk); #1; bus.in_valid = 1'b0;
    @(posedge clk); #1;
    total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL mid_early: got %b exp 0", bus.out_valid); end
    @(posedge clk); #1;
    total++;
    if (bus.out_valid !== 1'b1 || bus.out_data !== 16'h0600 || bus.out_tag !== 3'd6 || bus.out_sat !== 1'b0) begin
      bad++; $display("FAIL mid_next: got v=%b d=%h t=%0d s=%b exp v=1 d=0600 t=6 s=0", bus.out_valid, bus.out_data, bus.out_tag, bus.out_sat);
    end
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: got timeout exp completion");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_basic();
    test_bounds();
    test_stream();
    test_backpressure();
    test_random();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
